// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one external memory bus between the instruction-fetch
// port (ifu) and the load/store port (lsu). One transaction is in flight at a
// time. The response is routed only to the requester that was granted. A
// watchdog completes transactions that the bus never answers.
//
// Parameters
//   LSU_PRIORITY  1: lsu wins a simultaneous request; 0: round-robin
//   TIMEOUT       cycles allowed in WAIT before forced completion (0 = off)
//   ERR_RDATA     read data returned on a timed-out transaction
//
// Ports
//   clock, reset                  clock, asynchronous active-high reset
//   ifu_reqValid/ifu_addr         fetch request (word read)
//   ifu_respValid/ifu_rdata       fetch completion (combinational) and data
//   lsu_req*/lsu_addr/size/wen/wdata/wmask   load/store request
//   lsu_respValid/lsu_rdata       load/store completion (combinational) and data
//   bus_reqValid + bus_* fields   registered request to memory
//   bus_respValid/bus_rdata       memory completion and read data
//   err                           sticky timeout flag
module mem_arbiter #(
   parameter bit          LSU_PRIORITY = 1'b1,
   parameter int unsigned TIMEOUT      = 255,
   parameter logic [31:0] ERR_RDATA    = 32'h0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        ifu_reqValid,
   input  logic [31:0] ifu_addr,
   output logic        ifu_respValid,
   output logic [31:0] ifu_rdata,
   input  logic        lsu_reqValid,
   input  logic [31:0] lsu_addr,
   input  logic [1:0]  lsu_size,
   input  logic        lsu_wen,
   input  logic [31:0] lsu_wdata,
   input  logic [3:0]  lsu_wmask,
   output logic        lsu_respValid,
   output logic [31:0] lsu_rdata,
   output logic        bus_reqValid,
   output logic [31:0] bus_addr,
   output logic [1:0]  bus_size,
   output logic        bus_wen,
   output logic [31:0] bus_wdata,
   output logic [3:0]  bus_wmask,
   input  logic        bus_respValid,
   input  logic [31:0] bus_rdata,
   output logic        err
);

   localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic             grant;        // 0 = ifu, 1 = lsu
   logic             last_grant;
   logic [CNT_W-1:0] cnt;
   logic [31:0]      ifu_rdata_q;
   logic [31:0]      lsu_rdata_q;

   logic             accept_c;
   logic             pick_lsu_c;
   logic             done_c;
   logic             timeout_c;
   logic [31:0]      resp_data_c;

   // State register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state, arbitration and completion decode
   always_comb begin
      state_nxt  = state;
      accept_c   = 1'b0;
      pick_lsu_c = 1'b0;
      done_c     = 1'b0;
      timeout_c  = 1'b0;
      case (state)
         S_IDLE: begin
            if (ifu_reqValid || lsu_reqValid) begin
               accept_c  = 1'b1;
               state_nxt = S_ISSUE;
               if (ifu_reqValid && lsu_reqValid) begin
                  pick_lsu_c = LSU_PRIORITY ? 1'b1 : ~last_grant;
               end else begin
                  pick_lsu_c = lsu_reqValid;
               end
            end
         end
         S_ISSUE: begin
            state_nxt = S_WAIT;
         end
         S_WAIT: begin
            // A real response wins over a watchdog expiry in the same cycle
            if (bus_respValid) begin
               done_c    = 1'b1;
               state_nxt = S_IDLE;
            end else if ((TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1))) begin
               done_c    = 1'b1;
               timeout_c = 1'b1;
               state_nxt = S_IDLE;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   assign resp_data_c   = bus_respValid ? bus_rdata : ERR_RDATA;
   assign ifu_respValid = done_c & ~grant;
   assign lsu_respValid = done_c & grant;
   assign ifu_rdata     = ifu_respValid ? resp_data_c : ifu_rdata_q;
   assign lsu_rdata     = lsu_respValid ? resp_data_c : lsu_rdata_q;

   // Request capture, bus strobe, watchdog, fairness and error tracking
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         grant        <= 1'b0;
         last_grant   <= 1'b0;
         cnt          <= '0;
         err          <= 1'b0;
         bus_reqValid <= 1'b0;
         bus_addr     <= '0;
         bus_size     <= '0;
         bus_wen      <= 1'b0;
         bus_wdata    <= '0;
         bus_wmask    <= '0;
         ifu_rdata_q  <= '0;
         lsu_rdata_q  <= '0;
      end else begin
         // Accept happens only in IDLE, so the strobe is high exactly in ISSUE
         bus_reqValid <= accept_c;
         if (accept_c) begin
            grant <= pick_lsu_c;
            if (pick_lsu_c) begin
               bus_addr  <= lsu_addr;
               bus_size  <= lsu_size;
               bus_wen   <= lsu_wen;
               bus_wdata <= lsu_wdata;
               bus_wmask <= lsu_wmask;
            end else begin
               bus_addr  <= ifu_addr;
               bus_size  <= 2'b10;
               bus_wen   <= 1'b0;
               bus_wdata <= '0;
               bus_wmask <= '0;
            end
         end
         if (state == S_ISSUE) begin
            cnt <= '0;
         end else if (state == S_WAIT) begin
            cnt <= cnt + 1'b1;
         end
         // Timed-out transactions still count as served for round-robin
         if (done_c) begin
            last_grant <= grant;
         end
         if (timeout_c) begin
            err <= 1'b1;
         end
         if (ifu_respValid) begin
            ifu_rdata_q <= resp_data_c;
         end
         if (lsu_respValid) begin
            lsu_rdata_q <= resp_data_c;
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (lsu priority and round-robin) share
// stimulus; one is observed at a time. Requesters and a bus responder are
// modelled; expected bus requests are queued in the order they must be served.
module tb_mem_arbiter;

   localparam int unsigned TO   = 4;
   localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

   typedef struct {
      logic        port;
      logic [31:0] addr;
      logic [1:0]  size;
      logic        wen;
      logic [31:0] wdata;
      logic [3:0]  wmask;
      int          delay;
      logic [31:0] rdata;
   } txn_t;

   logic        clock = 1'b0;
   logic        reset;
   logic        ifu_req;
   logic [31:0] ifu_addr;
   logic        lsu_req;
   logic [31:0] lsu_addr;
   logic [1:0]  lsu_size;
   logic        lsu_wen;
   logic [31:0] lsu_wdata;
   logic [3:0]  lsu_wmask;
   logic        bus_rv;
   logic [31:0] bus_rd;

   logic [1:0]       ifu_rv_d;
   logic [1:0][31:0] ifu_rd_d;
   logic [1:0]       lsu_rv_d;
   logic [1:0][31:0] lsu_rd_d;
   logic [1:0]       bus_req_d;
   logic [1:0][31:0] bus_addr_d;
   logic [1:0][1:0]  bus_size_d;
   logic [1:0]       bus_wen_d;
   logic [1:0][31:0] bus_wdata_d;
   logic [1:0][3:0]  bus_wmask_d;
   logic [1:0]       err_d;

   logic        sel;
   logic        o_ifu_rv, o_lsu_rv, o_bus_req, o_wen, o_err;
   logic [31:0] o_ifu_rd, o_lsu_rd, o_addr, o_wdata;
   logic [1:0]  o_size;
   logic [3:0]  o_wmask;

   always #5 clock = ~clock;

   mem_arbiter #(.LSU_PRIORITY(1'b1), .TIMEOUT(TO), .ERR_RDATA(ERRD)) u_pri (
      .clock(clock), .reset(reset),
      .ifu_reqValid(ifu_req), .ifu_addr(ifu_addr),
      .ifu_respValid(ifu_rv_d[0]), .ifu_rdata(ifu_rd_d[0]),
      .lsu_reqValid(lsu_req), .lsu_addr(lsu_addr), .lsu_size(lsu_size),
      .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
      .lsu_respValid(lsu_rv_d[0]), .lsu_rdata(lsu_rd_d[0]),
      .bus_reqValid(bus_req_d[0]), .bus_addr(bus_addr_d[0]), .bus_size(bus_size_d[0]),
      .bus_wen(bus_wen_d[0]), .bus_wdata(bus_wdata_d[0]), .bus_wmask(bus_wmask_d[0]),
      .bus_respValid(bus_rv), .bus_rdata(bus_rd), .err(err_d[0])
   );

   mem_arbiter #(.LSU_PRIORITY(1'b0), .TIMEOUT(TO), .ERR_RDATA(ERRD)) u_rr (
      .clock(clock), .reset(reset),
      .ifu_reqValid(ifu_req), .ifu_addr(ifu_addr),
      .ifu_respValid(ifu_rv_d[1]), .ifu_rdata(ifu_rd_d[1]),
      .lsu_reqValid(lsu_req), .lsu_addr(lsu_addr), .lsu_size(lsu_size),
      .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
      .lsu_respValid(lsu_rv_d[1]), .lsu_rdata(lsu_rd_d[1]),
      .bus_reqValid(bus_req_d[1]), .bus_addr(bus_addr_d[1]), .bus_size(bus_size_d[1]),
      .bus_wen(bus_wen_d[1]), .bus_wdata(bus_wdata_d[1]), .bus_wmask(bus_wmask_d[1]),
      .bus_respValid(bus_rv), .bus_rdata(bus_rd), .err(err_d[1])
   );

   always_comb begin
      o_ifu_rv  = ifu_rv_d[sel];
      o_ifu_rd  = ifu_rd_d[sel];
      o_lsu_rv  = lsu_rv_d[sel];
      o_lsu_rd  = lsu_rd_d[sel];
      o_bus_req = bus_req_d[sel];
      o_addr    = bus_addr_d[sel];
      o_size    = bus_size_d[sel];
      o_wen     = bus_wen_d[sel];
      o_wdata   = bus_wdata_d[sel];
      o_wmask   = bus_wmask_d[sel];
      o_err     = err_d[sel];
   end

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Model state
   txn_t        rq_ifu[$];
   txn_t        rq_lsu[$];
   txn_t        bq[$];
   txn_t        cur;
   bit          busy = 1'b0;
   int          wait_k = 0;
   bit          force_late = 1'b0;
   logic [1:0]  exp_rv = 2'b00;
   logic [31:0] exp_rd [2];
   logic [31:0] last_rd [2];
   bit          exp_err = 1'b0;
   bit          err_pend = 1'b0;
   bit [1:0]    act = 2'b00;
   int          cyc_n = 0;
   int          t_req [2];
   int          t_rsp [2];
   int          t_issue = 0;

   task automatic add(input bit port, input logic [31:0] addr, input logic [1:0] size,
                      input bit wen, input logic [31:0] wdata, input logic [3:0] wmask,
                      input int delay, input logic [31:0] rdata);
      txn_t t;
      t.port  = port;
      t.addr  = addr;
      t.delay = delay;
      t.rdata = rdata;
      if (port) begin
         t.size = size; t.wen = wen; t.wdata = wdata; t.wmask = wmask;
         rq_lsu.push_back(t);
      end else begin
         t.size = 2'b10; t.wen = 1'b0; t.wdata = '0; t.wmask = '0;
         rq_ifu.push_back(t);
      end
      bq.push_back(t);
   endtask

   // Drive one cycle of inputs, just after the rising edge
   task automatic drive();
      cyc_n++;
      exp_rv = 2'b00;
      bus_rv = 1'b0;
      bus_rd = $urandom();
      if (err_pend) begin
         exp_err  = 1'b1;
         err_pend = 1'b0;
      end
      if (force_late) begin
         bus_rv     = 1'b1;
         force_late = 1'b0;
      end else if (busy) begin
         wait_k++;
         if (cur.delay + 1 == wait_k) begin
            bus_rv              = 1'b1;
            bus_rd              = cur.rdata;
            exp_rv[cur.port]    = 1'b1;
            exp_rd[cur.port]    = cur.rdata;
            busy                = 1'b0;
         end else if (wait_k == int'(TO)) begin
            exp_rv[cur.port]    = 1'b1;
            exp_rd[cur.port]    = ERRD;
            err_pend            = 1'b1;
            busy                = 1'b0;
         end
      end
      ifu_req  = (rq_ifu.size() != 0);
      ifu_addr = ifu_req ? rq_ifu[0].addr : $urandom();
      lsu_req  = (rq_lsu.size() != 0);
      if (lsu_req) begin
         lsu_addr  = rq_lsu[0].addr;
         lsu_size  = rq_lsu[0].size;
         lsu_wen   = rq_lsu[0].wen;
         lsu_wdata = rq_lsu[0].wdata;
         lsu_wmask = rq_lsu[0].wmask;
      end else begin
         lsu_addr  = $urandom();
         lsu_size  = 2'($urandom());
         lsu_wen   = 1'($urandom());
         lsu_wdata = $urandom();
         lsu_wmask = 4'($urandom());
      end
      if (ifu_req && !act[0]) begin act[0] = 1'b1; t_req[0] = cyc_n; end
      if (lsu_req && !act[1]) begin act[1] = 1'b1; t_req[1] = cyc_n; end
   endtask

   // Check outputs on the falling edge and advance the requester/bus models
   task automatic sample();
      chk("ifu_rv", 32'(o_ifu_rv), 32'(exp_rv[0]));
      if (exp_rv[0]) last_rd[0] = exp_rd[0];
      chk("ifu_rdata", o_ifu_rd, last_rd[0]);
      chk("lsu_rv", 32'(o_lsu_rv), 32'(exp_rv[1]));
      if (exp_rv[1]) last_rd[1] = exp_rd[1];
      chk("lsu_rdata", o_lsu_rd, last_rd[1]);
      chk("err", 32'(o_err), 32'(exp_err));
      if (o_bus_req) begin
         if (busy || bq.size() == 0) begin
            chk("bus_spurious_req", 32'(1), 32'(0));
         end else begin
            cur     = bq.pop_front();
            busy    = 1'b1;
            wait_k  = 0;
            t_issue = cyc_n;
            chk("bus_addr", o_addr, cur.addr);
            chk("bus_size", 32'(o_size), 32'(cur.size));
            chk("bus_wen", 32'(o_wen), 32'(cur.wen));
            chk("bus_wdata", o_wdata, cur.wdata);
            chk("bus_wmask", 32'(o_wmask), 32'(cur.wmask));
         end
      end else if (busy) begin
         chk("bus_addr_hold", o_addr, cur.addr);
         chk("bus_wdata_hold", o_wdata, cur.wdata);
      end
      if (o_ifu_rv && rq_ifu.size() != 0) begin
         void'(rq_ifu.pop_front());
         act[0]   = 1'b0;
         t_rsp[0] = cyc_n;
      end
      if (o_lsu_rv && rq_lsu.size() != 0) begin
         void'(rq_lsu.pop_front());
         act[1]   = 1'b0;
         t_rsp[1] = cyc_n;
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
      drive();
      @(negedge clock);
      sample();
   endtask

   task automatic run(input int budget);
      int n;
      n = 0;
      while ((rq_ifu.size() != 0 || rq_lsu.size() != 0 || bq.size() != 0 || busy) && n < budget) begin
         step();
         n++;
      end
      if (n >= budget) chk("run_budget", 32'(1), 32'(0));
   endtask

   task automatic do_reset();
      @(posedge clock);
      #1;
      reset = 1'b1;
      rq_ifu.delete();
      rq_lsu.delete();
      bq.delete();
      busy       = 1'b0;
      act        = 2'b00;
      exp_rv     = 2'b00;
      last_rd[0] = '0;
      last_rd[1] = '0;
      exp_err    = 1'b0;
      err_pend   = 1'b0;
      ifu_req    = 1'b0;
      lsu_req    = 1'b0;
      bus_rv     = 1'b0;
      #2;
      chk("rst_bus_req", 32'(o_bus_req), 32'(0));
      chk("rst_bus_addr", o_addr, 32'(0));
      chk("rst_bus_size", 32'(o_size), 32'(0));
      chk("rst_bus_wen", 32'(o_wen), 32'(0));
      chk("rst_bus_wdata", o_wdata, 32'(0));
      chk("rst_bus_wmask", 32'(o_wmask), 32'(0));
      chk("rst_ifu_rv", 32'(o_ifu_rv), 32'(0));
      chk("rst_lsu_rv", 32'(o_lsu_rv), 32'(0));
      chk("rst_ifu_rdata", o_ifu_rd, 32'(0));
      chk("rst_lsu_rdata", o_lsu_rd, 32'(0));
      chk("rst_err", 32'(o_err), 32'(0));
      @(posedge clock);
      #1;
      reset = 1'b0;
      drive();
      @(negedge clock);
      sample();
   endtask

   initial begin
      reset     = 1'b1;
      sel       = 1'b0;
      ifu_req   = 1'b0;
      ifu_addr  = '0;
      lsu_req   = 1'b0;
      lsu_addr  = '0;
      lsu_size  = '0;
      lsu_wen   = 1'b0;
      lsu_wdata = '0;
      lsu_wmask = '0;
      bus_rv    = 1'b0;
      bus_rd    = '0;
      exp_rd[0] = '0; exp_rd[1] = '0;
      t_req[0] = 0; t_req[1] = 0; t_rsp[0] = 0; t_rsp[1] = 0;

      // lsu-priority instance
      do_reset();

      add(1'b0, 32'h8000_0000, 2'd0, 1'b0, 32'h0, 4'h0, 0, 32'h0000_0013);
      run(40);
      chk("fetch_latency", 32'(t_rsp[0] - t_req[0] + 1), 32'(3));

      add(1'b1, 32'h0000_1000, 2'd0, 1'b1, 32'h0000_00AB, 4'b0001, 2, 32'h1234_5678);
      run(40);
      add(1'b1, 32'h0000_2004, 2'd2, 1'b0, 32'h0, 4'h0, 1, 32'hCAFE_F00D);
      run(40);

      // Simultaneous: lsu first, then ifu
      add(1'b1, 32'h0000_3000, 2'd1, 1'b1, 32'h0000_BEEF, 4'b0011, 0, 32'h0000_0033);
      add(1'b0, 32'h8000_0004, 2'd0, 1'b0, 32'h0, 4'h0, 0, 32'h0000_0044);
      run(60);

      // Watchdog: no bus response
      add(1'b0, 32'h8000_0008, 2'd0, 1'b0, 32'h0, 4'h0, 99, 32'h0);
      run(40);
      chk("timeout_latency", 32'(t_rsp[0] - t_issue), 32'(TO));
      add(1'b1, 32'h0000_2008, 2'd2, 1'b0, 32'h0, 4'h0, 0, 32'h0BAD_F00D);
      run(40);
      repeat (2) step();

      // Reset while in WAIT, then a stale bus response
      add(1'b1, 32'h0000_4000, 2'd2, 1'b0, 32'h0, 4'h0, 99, 32'h0);
      for (int i = 0; i < 20 && !(busy && wait_k == 2); i++) step();
      chk("reached_wait", 32'(busy && wait_k == 2), 32'(1));
      do_reset();
      force_late = 1'b1;
      step();
      step();
      add(1'b0, 32'h8000_0100, 2'd0, 1'b0, 32'h0, 4'h0, 0, 32'h0000_0011);
      run(40);

      // Round-robin instance
      sel = 1'b1;
      do_reset();
      add(1'b1, 32'h0000_5000, 2'd2, 1'b0, 32'h0, 4'h0, 0, 32'h0000_0055);
      run(40);
      // last_grant is now lsu: ifu, lsu, ifu, lsu
      add(1'b0, 32'h8000_0200, 2'd0, 1'b0, 32'h0, 4'h0, 0, 32'h0000_00A0);
      add(1'b1, 32'h0000_5004, 2'd2, 1'b0, 32'h0, 4'h0, 1, 32'h0000_00B0);
      add(1'b0, 32'h8000_0204, 2'd0, 1'b0, 32'h0, 4'h0, 0, 32'h0000_00A1);
      add(1'b1, 32'h0000_5008, 2'd1, 1'b1, 32'h0000_BEEF, 4'b0011, 2, 32'h0000_00B1);
      run(100);
      repeat (2) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares the single external memory bus between the CPU's instruction-fetch port (ifu) and load/store port (lsu). Sits between the cpu top-level io_ifu_*/io_lsu_* ports and the SoC memory bus. Selects one requester, captures its request, issues it on the bus, and routes the response back to that requester only. A watchdog terminates bus transactions that never respond.

Parameters:
LSU_PRIORITY, 1, 1 = LSU always wins a simultaneous request; 0 = round-robin, where the requester not granted last wins.
TIMEOUT, 255, max cycles in WAIT before forced completion; 0 disables the watchdog.
ERR_RDATA, 32'h0, rdata returned on a timed-out transaction.

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
ifu_reqValid  in  1  fetch request; addr held stable until ifu_respValid
ifu_addr  in  32  fetch address (size fixed 2'b10, wen 0)
ifu_respValid  out  1  one-cycle fetch completion
ifu_rdata  out  32  fetch data, valid with ifu_respValid
lsu_reqValid  in  1  load/store request; fields held stable until lsu_respValid
lsu_addr  in  32  load/store address
lsu_size  in  2  0 = byte, 1 = half, 2 = word
lsu_wen  in  1  1 = store
lsu_wdata  in  32  store data
lsu_wmask  in  4  store byte mask
lsu_respValid  out  1  one-cycle load/store completion
lsu_rdata  out  32  load data, valid with lsu_respValid
bus_reqValid  out  1  one-cycle request strobe to memory
bus_addr, bus_size, bus_wen, bus_wdata, bus_wmask  out  32/2/1/32/4  registered request fields
bus_respValid  in  1  memory completion
bus_rdata  in  32  memory read data
err  out  1  sticky timeout flag

Behaviour:
- FSM states: IDLE, ISSUE, WAIT. Registers: grant (0 = ifu, 1 = lsu), last_grant, request fields, timeout counter, err.
- Reset values: state IDLE; bus_reqValid 0; all bus_* fields 0; ifu/lsu_respValid 0; ifu/lsu_rdata 0; err 0; last_grant 0; counter 0.
- Reset asserted mid-transaction aborts it. No respValid is produced for the aborted transaction, and any late bus_respValid after reset is ignored in IDLE.
- IDLE: if any reqValid is high, select the winner, latch its fields (ifu: size 2, wen 0, wdata 0, wmask 0), set grant, and move to ISSUE next cycle.
  - Single requester: it wins.
  - Both requesting, LSU_PRIORITY = 1: lsu wins.
  - Both requesting, LSU_PRIORITY = 0: the requester != last_grant wins.
- ISSUE: bus_reqValid = 1 for exactly this cycle; clear the counter; move to WAIT next cycle.
- WAIT: bus_reqValid = 0; bus_* fields stay stable.
  - On bus_respValid: same cycle, drive the granted requester's respValid = 1 and rdata = bus_rdata (combinational); the other requester's respValid stays 0. Update last_grant = grant and go to IDLE.
  - Else, if TIMEOUT != 0 and counter == TIMEOUT - 1: drive the granted requester's respValid = 1 with rdata = ERR_RDATA, set err = 1 (sticky until reset), and go to IDLE.
  - Else counter increments.
- Minimum latency, request to respValid: 3 cycles (IDLE accept, ISSUE, WAIT with immediate bus_respValid).
- bus_respValid in IDLE or ISSUE is ignored; no response is generated.
- A requester still holding reqValid in the cycle after its respValid starts a new transaction. Requesters deassert in the cycle after respValid when no new access is wanted.
- ifu/lsu_rdata hold their last value when respValid is 0.
- A request arriving while another transaction is in flight waits and is served from IDLE after completion.
- Non-granted requester signals never alter the latched bus_* fields mid-transaction.

Test Plan:
- Single fetch: ifu_reqValid = 1, ifu_addr = 0x8000_0000; bus_respValid one cycle after ISSUE with rdata 0x0000_0013 -> bus_reqValid pulses once with addr 0x8000_0000, size 2, wen 0; ifu_respValid = 1, ifu_rdata = 0x13 three cycles after request; lsu_respValid stays 0.
- Store pass-through: lsu addr 0x1000, size 0, wen 1, wdata 0xAB, wmask 4'b0001 -> bus fields match exactly; lsu_respValid on bus_respValid.
- Simultaneous requests, LSU_PRIORITY = 1 -> lsu served first, then ifu; LSU_PRIORITY = 0 with last_grant = lsu -> ifu served first.
- Round-robin fairness, LSU_PRIORITY = 0, both held high for 4 transactions -> grant order alternates ifu, lsu, ifu, lsu.
- Timeout, TIMEOUT = 4, no bus_respValid -> requester respValid asserts 4 cycles after ISSUE with rdata = ERR_RDATA; err = 1 and stays high until reset.
- Reset asserted during WAIT, then bus_respValid arrives after reset release -> no respValid; all outputs at reset values; next request handled normally.
